// File: rtl/credit_req_rsp_bridge_pkg.sv
// Shared types and constants for the credit request/response bridge.
// Revision: 1.0
`default_nettype none

package credit_req_rsp_bridge_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_DATA = 2'b01
  } rsp_cmd_e;

  localparam int CNT_W = 4;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/crb_fifo.sv
// Per-channel FIFO; a full FIFO still accepts a push when popped in the same cycle.
// Revision: 1.0
`default_nettype none

module crb_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_dout,
  output logic          o_empty,
  output logic          o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wp;
  logic [AW:0]   r_rp;
  logic          w_wr;
  logic          w_rd;

  // Extra MSB on each pointer separates full from empty when the indices match.
  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_dout  = r_mem[r_rp[AW-1:0]];
  assign w_wr    = i_push && (!o_full || i_pop);
  assign w_rd    = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp[AW-1:0]] <= i_din;
        r_wp                <= r_wp + 1'b1;
      end
      if (w_rd) begin
        r_rp <= r_rp + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/credit_req_rsp_bridge.sv
// Round-robin bridge from NCH credited request FIFOs to one credited response port.
// Optional error flags: define CREDIT_REQ_RSP_BRIDGE_ERR_CHK_EN. Revision: 1.0
`default_nettype none

module credit_req_rsp_bridge
  import credit_req_rsp_bridge_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int DW          = 64,
  parameter int DEPTH       = 4,
  parameter int RSP_CREDITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             req_val,
  input  logic [NCH*DW-1:0]          req_dat,
  output logic [NCH-1:0]             req_credit,
  output logic [1:0]                 rsp_cmd,
  output logic [DW-1:0]              rsp_data,
  output logic [ch_width(NCH)-1:0]   rsp_ch,
  input  logic                       rsp_credit,
  output logic [NCH-1:0]             err
);

  localparam int              CW        = ch_width(NCH);
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(RSP_CREDITS);
  localparam logic [0:0]      ST_IDLE   = 1'b0;
  localparam logic [0:0]      ST_ISSUE  = 1'b1;

  logic [DW-1:0]    w_dout [NCH];
  logic [NCH-1:0]   w_empty;
  logic [NCH-1:0]   w_full;
  logic [NCH-1:0]   w_pop;
  logic             w_found;
  logic [CW-1:0]    w_gnt;
  logic [0:0]       w_state;
  logic             w_issue;
  logic             w_inc;

  rsp_cmd_e         r_cmd;
  logic [DW-1:0]    r_data;
  logic [CW-1:0]    r_ch;
  logic [NCH-1:0]   r_credit;
  logic [CNT_W-1:0] r_cnt;
  logic [CW-1:0]    r_last;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      crb_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (req_val[gi]),
        .i_din   (req_dat[gi*DW +: DW]),
        .i_pop   (w_pop[gi]),
        .o_dout  (w_dout[gi]),
        .o_empty (w_empty[gi]),
        .o_full  (w_full[gi])
      );
    end
  endgenerate

  // Search starts one past the last grant so every busy channel gets a turn.
  always_comb begin
    logic [CW-1:0] sel;
    w_found = 1'b0;
    w_gnt   = '0;
    sel     = '0;
    for (int k = 1; k <= NCH; k++) begin
      sel = CW'((int'(r_last) + k) % NCH);
      if (!w_found && !w_empty[sel]) begin
        w_found = 1'b1;
        w_gnt   = sel;
      end
    end
  end

  assign w_state = (w_found && (r_cnt != '0)) ? ST_ISSUE : ST_IDLE;
  assign w_issue = (w_state == ST_ISSUE);
  assign w_inc   = rsp_credit && (r_cnt != c_CNT_MAX);

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < NCH; k++) begin
      w_pop[k] = w_issue && (w_gnt == CW'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd    <= CMD_NOP;
      r_data   <= '0;
      r_ch     <= '0;
      r_credit <= '0;
      r_cnt    <= c_CNT_MAX;
      r_last   <= CW'(NCH - 1);
    end else begin
      r_credit <= w_pop;
      if (w_issue) begin
        r_cmd  <= CMD_DATA;
        r_data <= w_dout[w_gnt];
        r_ch   <= w_gnt;
        r_last <= w_gnt;
      end else begin
        r_cmd  <= CMD_NOP;
        r_data <= '0;
        r_ch   <= '0;
      end
      if (w_issue && !w_inc) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end else if (!w_issue && w_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign rsp_cmd    = r_cmd;
  assign rsp_data   = r_data;
  assign rsp_ch     = r_ch;
  assign req_credit = r_credit;

`ifdef CREDIT_REQ_RSP_BRIDGE_ERR_CHK_EN
  logic [NCH-1:0] r_err;
  logic [NCH-1:0] w_err_set;

  always_comb begin
    w_err_set    = req_val & w_full & ~w_pop;
    w_err_set[0] = w_err_set[0] | (rsp_credit && (r_cnt == c_CNT_MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= '0;
    end else begin
      r_err <= r_err | w_err_set;
    end
  end

  assign err = r_err;
`else
  logic w_unused_full;
  assign w_unused_full = &{1'b0, w_full};
  assign err           = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_credit_req_rsp_bridge.sv
// Directed and random checks of credit_req_rsp_bridge against a queue-based reference model.
`default_nettype none

module tb_credit_req_rsp_bridge;

  localparam int NCH   = 2;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int CRED  = 4;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic [1:0]    req_val    = '0;
  logic [127:0]  req_dat    = '0;
  logic          rsp_credit = 1'b0;
  logic [1:0]    req_credit;
  logic [1:0]    rsp_cmd;
  logic [63:0]   rsp_data;
  logic [0:0]    rsp_ch;
  logic [1:0]    err;

  credit_req_rsp_bridge #(
    .NCH         (NCH),
    .DW          (DW),
    .DEPTH       (DEPTH),
    .RSP_CREDITS (CRED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_val    (req_val),
    .req_dat    (req_dat),
    .req_credit (req_credit),
    .rsp_cmd    (rsp_cmd),
    .rsp_data   (rsp_data),
    .rsp_ch     (rsp_ch),
    .rsp_credit (rsp_credit),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_data   = 0;

  // Reference model: one queue per channel plus scalar credit and round-robin state.
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  int          mcnt  = CRED;
  int          mlast = NCH - 1;
  logic [1:0]  e_cmd  = '0;
  logic [63:0] e_data = '0;
  logic [0:0]  e_ch   = '0;
  logic [1:0]  e_cred = '0;
  logic [1:0]  e_err  = '0;
  int          obs_ch[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  task automatic step(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                      input logic rc, input logic r);
    int old_cnt;
    int ch;
    int c;
    logic [63:0] pd;
    req_val    = v;
    req_dat    = {d1, d0};
    rsp_credit = rc;
    rst        = r;
    @(posedge clk);
    if (r) begin
      q0.delete();
      q1.delete();
      mcnt   = CRED;
      mlast  = NCH - 1;
      e_cmd  = '0;
      e_data = '0;
      e_ch   = '0;
      e_cred = '0;
      e_err  = '0;
    end else begin
      old_cnt = mcnt;
      ch      = -1;
      if (old_cnt > 0) begin
        for (int k = 1; k <= NCH; k++) begin
          c = (mlast + k) % NCH;
          if (ch < 0 && qsize(c) > 0) ch = c;
        end
      end
      e_cred = '0;
      if (ch >= 0) begin
        if (ch == 0) pd = q0.pop_front();
        else         pd = q1.pop_front();
        e_cmd      = 2'b01;
        e_data     = pd;
        e_ch       = ch[0];
        e_cred[ch] = 1'b1;
        mlast      = ch;
        mcnt       = mcnt - 1;
      end else begin
        e_cmd  = 2'b00;
        e_data = '0;
        e_ch   = '0;
      end
      if (rc && old_cnt < CRED) mcnt = mcnt + 1;
      if (v[0]) begin
        if (q0.size() < DEPTH) q0.push_back(d0);
`ifdef CREDIT_REQ_RSP_BRIDGE_ERR_CHK_EN
        else e_err[0] = 1'b1;
`endif
      end
      if (v[1]) begin
        if (q1.size() < DEPTH) q1.push_back(d1);
`ifdef CREDIT_REQ_RSP_BRIDGE_ERR_CHK_EN
        else e_err[1] = 1'b1;
`endif
      end
`ifdef CREDIT_REQ_RSP_BRIDGE_ERR_CHK_EN
      if (rc && old_cnt == CRED) e_err[0] = 1'b1;
`endif
    end
    #1;
    chk("rsp_cmd",    64'(rsp_cmd),    64'(e_cmd));
    chk("rsp_data",   rsp_data,        e_data);
    chk("rsp_ch",     64'(rsp_ch),     64'(e_ch));
    chk("req_credit", 64'(req_credit), 64'(e_cred));
    chk("err",        64'(err),        64'(e_err));
    if (rsp_cmd == 2'b01) begin
      n_data++;
      obs_ch.push_back(int'(rsp_ch));
    end
  endtask

  task automatic idle(input int n, input logic rc);
    for (int i = 0; i < n; i++) step(2'b00, '0, '0, rc, 1'b0);
  endtask

  initial begin
    int base;
    logic [1:0]  rv;
    logic [63:0] rd0;
    logic [63:0] rd1;
    logic        rrc;
    logic        rr;

    // Reset state
    step(2'b00, '0, '0, 1'b0, 1'b1);
    step(2'b00, '0, '0, 1'b0, 1'b1);

    // Two-cycle latency on ch0
    step(2'b01, 64'hA5A5_0000_1234_5678, '0, 1'b0, 1'b0);
    chk("lat_not_early", 64'(rsp_cmd), 64'd0);
    step(2'b00, '0, '0, 1'b0, 1'b0);
    chk("lat_cmd",  64'(rsp_cmd),    64'd1);
    chk("lat_data", rsp_data,        64'hA5A5_0000_1234_5678);
    chk("lat_cred", 64'(req_credit), 64'd1);
    idle(2, 1'b1);

    // Round-robin ordering with three entries per channel
    step(2'b00, '0, '0, 1'b0, 1'b1);
    obs_ch.delete();
    for (int i = 0; i < 3; i++) step(2'b11, 64'(100 + i), 64'(200 + i), 1'b0, 1'b0);
    idle(6, 1'b1);
    chk("rr_count", 64'(obs_ch.size()), 64'd6);
    for (int i = 0; i < 6 && i < obs_ch.size(); i++) chk("rr_order", 64'(obs_ch[i]), 64'(i % 2));

    // Downstream credit exhaustion and single-credit resume
    step(2'b00, '0, '0, 1'b0, 1'b1);
    base = n_data;
    for (int i = 0; i < 3; i++) step(2'b11, 64'(300 + i), 64'(400 + i), 1'b0, 1'b0);
    idle(5, 1'b0);
    chk("cred_stall_count", 64'(n_data - base), 64'd4);
    chk("cred_stall_nop",   64'(rsp_cmd),       64'd0);
    step(2'b00, '0, '0, 1'b1, 1'b0);
    step(2'b00, '0, '0, 1'b0, 1'b0);
    chk("cred_resume_cmd",   64'(rsp_cmd),       64'd1);
    chk("cred_resume_count", 64'(n_data - base), 64'd5);
    idle(4, 1'b1);

    // Overflow drop on ch1 while no downstream credit is available
    step(2'b00, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(2'b01, 64'(500 + i), '0, 1'b0, 1'b0);
    idle(2, 1'b0);
    for (int i = 0; i < 5; i++) step(2'b10, '0, 64'(600 + i), 1'b0, 1'b0);
`ifdef CREDIT_REQ_RSP_BRIDGE_ERR_CHK_EN
    chk("drop_err1", 64'(err[1]), 64'd1);
`else
    chk("drop_err1", 64'(err[1]), 64'd0);
`endif
    base = n_data;
    idle(4, 1'b1);
    idle(4, 1'b0);
    chk("drop_issue_count", 64'(n_data - base), 64'd4);

    // Reset with entries still buffered
    step(2'b00, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(2'b01, 64'(700 + i), '0, 1'b0, 1'b0);
    idle(2, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b10, '0, 64'(800 + i), 1'b0, 1'b0);
    step(2'b00, '0, '0, 1'b0, 1'b1);
    chk("rst_mid_cmd",  64'(rsp_cmd),    64'd0);
    chk("rst_mid_cred", 64'(req_credit), 64'd0);
    step(2'b00, '0, '0, 1'b0, 1'b0);
    chk("rst_mid_drained", 64'(rsp_cmd), 64'd0);
    base = n_data;
    for (int i = 0; i < 4; i++) step(2'b10, '0, 64'(900 + i), 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("rst_mid_cnt_restored", 64'(n_data - base), 64'd4);
    step(2'b00, '0, '0, 1'b0, 1'b1);
    step(2'b00, '0, '0, 1'b1, 1'b0);

    // Issue and credit return in the same cycle at cnt=2
    step(2'b00, '0, '0, 1'b0, 1'b1);
    base = n_data;
    step(2'b01, 64'd1000, '0, 1'b0, 1'b0);
    step(2'b01, 64'd1001, '0, 1'b0, 1'b0);
    step(2'b01, 64'd1002, '0, 1'b0, 1'b0);
    step(2'b01, 64'd1003, '0, 1'b1, 1'b0);
    step(2'b01, 64'd1004, '0, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("same_cycle_count", 64'(n_data - base), 64'd5);
    chk("same_cycle_nop",   64'(rsp_cmd),       64'd0);

    // Random traffic
    step(2'b00, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      rv  = 2'($urandom_range(0, 3));
      rd0 = {$urandom(), $urandom()};
      rd1 = {$urandom(), $urandom()};
      rrc = ($urandom_range(0, 2) == 0) && (mcnt < CRED || (q0.size() == 0 && q1.size() == 0));
      rr  = ($urandom_range(0, 99) == 0);
      step(rv, rd0, rd1, rrc, rr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
